shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 143 ++++++++++++++
 tb/tb_shift_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: drives clear/load/shift commands to an external shift
// register for a programmable number of iterations, with a per-iteration
// completion timeout and an abort path. Every output is a register.
module shift_sequencer #(
    parameter int CNT_W    = 11,
    parameter int WAIT_MAX = 7
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             start,
    input  logic [CNT_W-1:0] n_iter,
    input  logic             abort,
    input  logic             reg_done,
    output logic             reg_clrn,
    output logic             reg_load,
    output logic             reg_shift,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] iter_idx
);

    localparam int WC_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
        WAIT,
        FINISH
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [CNT_W-1:0]  idx_n;
    logic [CNT_W-1:0]  idx_inc;
    logic [WC_W-1:0]   wcnt, wcnt_n;
    logic              clrn_n, load_n, shift_n, busy_n, done_n, error_n;

    assign idx_inc = iter_idx + 1'b1;

    // Next-state, counters and next-cycle output values.
    // Outputs are registered from the current state, so each command is seen
    // one cycle after its state; busy therefore lags IDLE by one cycle and a
    // start is only accepted once busy has dropped.
    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = iter_idx;
        wcnt_n  = wcnt;
        clrn_n  = 1'b1;
        load_n  = 1'b0;
        shift_n = 1'b0;
        busy_n  = (state != IDLE);
        done_n  = 1'b0;
        error_n = 1'b0;

        case (state)
            IDLE: begin
                if (start && !busy) begin
                    count_n = n_iter;
                    idx_n   = '0;
                    state_n = (n_iter == '0) ? FINISH : CLEAR;
                end
            end
            CLEAR: begin
                clrn_n  = 1'b0;
                state_n = LOAD;
            end
            LOAD: begin
                load_n  = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                shift_n = 1'b1;
                wcnt_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (reg_done) begin
                    if (iter_idx != count) begin
                        idx_n = idx_inc;
                    end
                    state_n = (idx_inc == count) ? FINISH : SHIFT;
                end else if (wcnt == WC_W'(WAIT_MAX - 1)) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Abort overrides whatever the state decided this cycle.
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
            count_n = count;
            idx_n   = iter_idx;
            wcnt_n  = wcnt;
            clrn_n  = 1'b1;
            load_n  = 1'b0;
            shift_n = 1'b0;
            done_n  = 1'b0;
            error_n = 1'b1;
        end
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rest) begin
            state     <= IDLE;
            count     <= '0;
            iter_idx  <= '0;
            wcnt      <= '0;
            reg_clrn  <= 1'b0;
            reg_load  <= 1'b0;
            reg_shift <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            iter_idx  <= idx_n;
            wcnt      <= wcnt_n;
            reg_clrn  <= clrn_n;
            reg_load  <= load_n;
            reg_shift <= shift_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer: randomized shift-register response delays,
// with expected pulse timing derived from the cycle-count rules of the block.
module tb_shift_sequencer;

    localparam int CNT_W    = 11;
    localparam int WAIT_MAX = 7;

    logic             clk = 1'b0;
    logic             rest;
    logic             start;
    logic [CNT_W-1:0] n_iter;
    logic             abort;
    logic             reg_done;
    logic             reg_clrn;
    logic             reg_load;
    logic             reg_shift;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] iter_idx;

    int checks = 0;
    int passes = 0;

    // Response delay (cycles after a reg_shift pulse) per iteration; -1 = never.
    int k[2048];

    shift_sequencer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk      (clk),
        .rest     (rest),
        .start    (start),
        .n_iter   (n_iter),
        .abort    (abort),
        .reg_done (reg_done),
        .reg_clrn (reg_clrn),
        .reg_load (reg_load),
        .reg_shift(reg_shift),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .iter_idx (iter_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Runs one operation. Cycle 0 is the cycle in which start is driven.
    // abort_after = number of completed iterations after which abort is
    // raised (any value outside 0..n-1 means no abort).
    task automatic run(input int n, input int abort_after, input bit busy_start,
                       input string tag);
        int exp_done = -1;
        int exp_err  = -1;
        int exp_idx  = 0;
        int exp_clr  = (n == 0) ? 0 : 1;
        int exp_sh[$];
        int abort_cyc = -1;
        int t;
        int obs_done = -1;
        int obs_err  = -1;
        int clr = 0, ld = 0, sc = 0, both = 0, idx_end;
        int resp[$];
        int cyc;

        // Reference model: an iteration occupies (k+2) cycles, the first
        // reg_shift is seen in cycle 4, done two cycles after the last response.
        if (n == 0) begin
            exp_done = 2;
        end else begin
            t = 4;
            for (int i = 0; i < n; i++) begin
                if (abort_after == i) begin
                    abort_cyc = t - 1;
                    exp_err   = t;
                    break;
                end
                exp_sh.push_back(t);
                if (k[i] < 0) begin
                    exp_err = t + WAIT_MAX;
                    break;
                end
                exp_idx++;
                t += k[i] + 2;
                if (i == n - 1) exp_done = t;
            end
        end

        start    = 1'b1;
        n_iter   = CNT_W'(n);
        abort    = 1'b0;
        reg_done = 1'b0;
        step();
        start = busy_start;
        if (busy_start) n_iter = CNT_W'(9);
        cyc = 1;
        while (cyc < 20000) begin
            if (reg_shift) begin
                if (sc < exp_sh.size()) begin
                    check({tag, " shift_cycle"}, cyc, exp_sh[sc]);
                    check({tag, " idx_at_shift"}, int'(iter_idx), sc);
                    if (k[sc] >= 0) resp.push_back(cyc + k[sc]);
                end else begin
                    check({tag, " extra_shift"}, cyc, -1);
                end
                sc++;
            end
            if (!reg_clrn) clr++;
            if (reg_load) ld++;
            if (done && error) both++;
            if (done) obs_done = cyc;
            if (error) obs_err = cyc;
            if (done || error) break;
            reg_done = 1'b0;
            foreach (resp[j]) if (resp[j] == cyc) reg_done = 1'b1;
            abort = (cyc == abort_cyc);
            step();
            cyc++;
        end
        idx_end  = int'(iter_idx);
        start    = 1'b0;
        abort    = 1'b0;
        reg_done = 1'b0;

        check({tag, " done_cycle"}, obs_done, exp_done);
        check({tag, " error_cycle"}, obs_err, exp_err);
        check({tag, " shift_count"}, sc, exp_sh.size());
        check({tag, " clrn_count"}, clr, exp_clr);
        check({tag, " load_count"}, ld, exp_clr);
        check({tag, " iter_idx"}, idx_end, exp_idx);
        check({tag, " done_and_error"}, both, 0);

        step();
        check({tag, " busy_after"}, int'(busy), 0);
        check({tag, " no_extra_pulse"}, int'(done | error | reg_shift), 0);
        step();
        check({tag, " stays_idle"}, int'(busy), 0);
    endtask

    initial begin
        int n, a;
        bit found;

        rest     = 1'b1;
        start    = 1'b0;
        n_iter   = '0;
        abort    = 1'b0;
        reg_done = 1'b0;
        step();
        step();
        check("reset reg_clrn", int'(reg_clrn), 0);
        check("reset reg_load", int'(reg_load), 0);
        check("reset reg_shift", int'(reg_shift), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset error", int'(error), 0);
        check("reset iter_idx", int'(iter_idx), 0);
        rest = 1'b0;
        step();
        check("idle reg_clrn", int'(reg_clrn), 1);

        for (int i = 0; i < 3; i++) k[i] = 2;
        run(3, -1, 1'b0, "normal");

        run(0, -1, 1'b0, "zero");

        k[0] = -1;
        run(2, -1, 1'b0, "timeout");

        for (int i = 0; i < 5; i++) k[i] = int'($urandom_range(0, WAIT_MAX - 1));
        run(5, 2, 1'b0, "abort");

        for (int i = 0; i < 4; i++) k[i] = int'($urandom_range(0, WAIT_MAX - 1));
        run(4, -1, 1'b1, "busy_start");

        repeat (8) begin
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) k[i] = int'($urandom_range(0, WAIT_MAX - 1));
            if ($urandom_range(0, 3) == 0) k[$urandom_range(0, n - 1)] = -1;
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run(n, a, 1'($urandom_range(0, 1)), "random");
        end

        // Reset while waiting for the shift register.
        start  = 1'b1;
        n_iter = CNT_W'(3);
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (reg_shift) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("midreset reached_wait", int'(found), 1);
        rest = 1'b1;
        step();
        check("midreset busy", int'(busy), 0);
        check("midreset iter_idx", int'(iter_idx), 0);
        check("midreset reg_clrn", int'(reg_clrn), 0);
        check("midreset done_error", int'(done | error), 0);
        rest     = 1'b0;
        reg_done = 1'b1;
        step();
        reg_done = 1'b0;
        check("midreset clrn_idle", int'(reg_clrn), 1);
        repeat (3) begin
            step();
            check("midreset quiet", int'(done | error | busy | reg_shift), 0);
        end

        for (int i = 0; i < 2047; i++) k[i] = int'($urandom_range(0, 1));
        run(2047, -1, 1'b0, "max_count");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
